debounce_scheduler: RTL and testbench
=====================================

Name: debounce_scheduler

Overview:
- Time-multiplexed debounce controller for N_CH switch inputs; it shares one sampling-tick counter and one confirmation engine across all channels.
- Scans channels round-robin on each sampling tick and keeps a per-channel debounced level.
- Queues debounced edge events in a small FIFO behind a valid/ready handshake, so downstream control logic can consume button presses and releases.
- Replaces per-switch debounce instances in multi-button designs.

Parameters:
- N_CH, 4, number of switch channels (1..16)
- TICK_BITS, 20, tick period = 2^TICK_BITS clk cycles; must satisfy 2^TICK_BITS > N_CH+2
- CONFIRM, 3, consecutive differing samples required to flip a channel (1..7)
- FIFO_DEPTH, 4, event queue entries (power of 2, >=2)
- CH_W, derived, max(1, ceil(log2(N_CH)))

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sw  in  N_CH  raw switch inputs, asynchronous to clk
- db  out  N_CH  debounced levels
- tick  out  1  one-cycle sampling-tick pulse
- evt_valid  out  1  event FIFO non-empty
- evt_ready  in  1  consumer accepts head event
- evt_ch  out  CH_W  channel of head event
- evt_rise  out  1  1 = 0->1 edge, 0 = 1->0 edge
- overflow  out  1  sticky, event dropped on full FIFO
- clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Reset low clears:
  - tick counter, all cnt[i], synchronizers, FSM (IDLE), FIFO pointers
  - outputs: db=0, tick=0, evt_valid=0, overflow=0
  - evt_ch=0 and evt_rise=0 when empty
- Reset mid-scan aborts the scan. Queued events are lost.
- Input sync: sw passes through a 2-flop synchronizer per bit. "sample" below means the synchronized value.
- Tick counter:
  - Free-running, TICK_BITS wide.
  - tick=1 for exactly the cycle in which the counter equals all-ones; the counter then wraps to 0.
  - First tick occurs 2^TICK_BITS cycles after reset release.
- FSM states: IDLE, SCAN.
  - IDLE -> SCAN on tick, with idx=0.
  - SCAN processes channel idx in the current cycle, then idx++.
  - After idx=N_CH-1, SCAN -> IDLE.
  - A scan takes exactly N_CH cycles. A tick cannot arrive during SCAN, guaranteed by the TICK_BITS constraint.
- Per-channel processing (in SCAN, channel i=idx):
  - sample==db[i]: cnt[i] <= 0.
  - sample!=db[i] and cnt[i]+1 < CONFIRM: cnt[i] <= cnt[i]+1.
  - sample!=db[i] and cnt[i]+1 == CONFIRM: db[i] <= sample, cnt[i] <= 0, push event {ch=i, rise=sample}.
  - cnt[i] is 3 bits. Any disagreement-free sample restarts confirmation (glitch rejection).
- Latency:
  - db[i] changes the cycle after channel i's confirming scan slot.
  - The event is visible on evt_valid that same following cycle (show-ahead FIFO).
- FIFO handshake:
  - Pop when evt_valid && evt_ready.
  - evt_ch and evt_rise must stay stable while evt_valid=1 and evt_ready=0.
  - Events are delivered in push order.
- Boundary conditions:
  - Full and push, no pop: event dropped, overflow <= 1, db still updates.
  - Full with simultaneous push and pop: both accepted, count unchanged, no overflow.
  - Empty with push and evt_ready=1: no pop this cycle; the event appears next cycle.
  - clr_ovf and a new overflow in the same cycle: overflow stays 1 (set wins).
  - Pointer wrap at FIFO_DEPTH: full/empty are distinguished by an extra pointer bit.
- Only one push per cycle is possible, because only one channel is processed per cycle.

Test Plan:
All cases use TICK_BITS=4, N_CH=4, CONFIRM=3, FIFO_DEPTH=4.
- Reset low for 3 cycles mid-run, then high -> all outputs 0; first tick exactly 16 cycles after release; tick width 1 cycle.
- sw[2] 0->1 held -> db[2]=1 one cycle after channel 2's slot in the 3rd scan; single event {ch=2, rise=1}; evt_valid=1 until popped with evt_ready=1.
- sw[1] high for 2 ticks, low for 1 tick, high for 3 ticks -> no db[1] change until the 3rd consecutive high sample; exactly one rise event.
- All 4 channels toggle together with evt_ready=0 -> events ch0..ch3 queued in order; FIFO full; overflow stays 0. Further toggles of ch0 back to 0 -> overflow=1, db[0]=0, FIFO still holds the original 4 events.
- Full FIFO with evt_ready=1 in the same cycle a confirming push occurs -> pop and push both accepted, overflow unchanged, new event is last out.
- overflow=1 with clr_ovf=1 in a cycle without a drop -> overflow=0 next cycle. clr_ovf asserted in the same cycle as a drop -> overflow remains 1.

Source files
------------

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: shared-engine round-robin switch debouncer with an edge-event FIFO
module debounce_scheduler #(
  parameter int N_CH = 4,
  parameter int TICK_BITS = 20,
  parameter int CONFIRM = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_CH-1:0] sw_i,
  output logic [N_CH-1:0] db_o,
  output logic            tick_o,
  output logic            evt_valid_o,
  input  logic            evt_ready_i,
  output logic [CH_W-1:0] evt_ch_o,
  output logic            evt_rise_o,
  output logic            overflow_o,
  input  logic            clr_ovf_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, SCAN} state_e;
  state_e               state_q, state_d;
  logic [N_CH-1:0]      sync1_q, sync2_q, db_q, db_d;
  logic [N_CH-1:0][2:0] cnt_q, cnt_d;
  logic [TICK_BITS-1:0] tcnt_q;
  logic [CH_W-1:0]      idx_q, idx_d;
  logic [CH_W:0]        mem_q [FIFO_DEPTH];
  logic [AW:0]          wptr_q, rptr_q;
  logic                 ovf_q, smp, push, wr, pop, empty, full;
  assign tick_o      = &tcnt_q;
  assign smp         = sync2_q[idx_q];
  assign empty       = wptr_q == rptr_q;
  assign full        = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop         = !empty && evt_ready_i;
  assign wr          = push && (!full || pop);
  assign evt_valid_o = !empty;
  assign {evt_ch_o, evt_rise_o} = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign db_o        = db_q;
  assign overflow_o  = ovf_q;
  // One channel per scan cycle: count disagreeing samples, flip and emit an event on confirmation
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (state_q == IDLE) begin
      state_d = tick_o ? SCAN : IDLE;
      idx_d   = '0;
    end else begin
      if (smp == db_q[idx_q]) begin
        cnt_d[idx_q] = '0;
      end else if (cnt_q[idx_q] + 3'd1 == 3'(CONFIRM)) begin
        db_d[idx_q]  = smp;
        cnt_d[idx_q] = '0;
        push         = 1'b1;
      end else begin
        cnt_d[idx_q] = cnt_q[idx_q] + 3'd1;
      end
      idx_d   = idx_q + CH_W'(1);
      state_d = (idx_q == CH_W'(N_CH - 1)) ? IDLE : SCAN;
    end
  end
  // Synchronizers, tick counter, scan state, FIFO pointers and sticky overflow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      tcnt_q  <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      tcnt_q  <= tcnt_q + TICK_BITS'(1);
      state_q <= state_d;
      idx_q   <= idx_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wr ? wptr_q + (AW+1)'(1) : wptr_q;
      rptr_q  <= pop ? rptr_q + (AW+1)'(1) : rptr_q;
      ovf_q   <= (push && !wr) ? 1'b1 : clr_ovf_i ? 1'b0 : ovf_q;
    end
  end
  // Event storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= {idx_q, smp};
  end
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: scoreboard bench for the debounce scheduler
module tb_debounce_scheduler;
  logic       clk = 1'b0, rst_n = 1'b0, evt_ready = 1'b0, clr_ovf = 1'b0;
  logic [3:0] sw = '0, db;
  logic       tick, evt_valid, evt_rise, overflow;
  logic [1:0] evt_ch;
  logic [2:0] expq [$];
  int         total = 0, bad = 0;

  debounce_scheduler #(.N_CH(4), .TICK_BITS(4), .CONFIRM(3), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sw_i(sw), .db_o(db), .tick_o(tick),
    .evt_valid_o(evt_valid), .evt_ready_i(evt_ready), .evt_ch_o(evt_ch),
    .evt_rise_o(evt_rise), .overflow_o(overflow), .clr_ovf_i(clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the negedge of the next tick cycle (scan starts on the following edge)
  task automatic wait_tick();
    bit seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tick) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: got no tick, required one within 40 cycles");
    end
  endtask

  task automatic wait_scans(input int n);
    repeat (n) wait_tick();
  endtask

  // Wait for the head event, compare it with the scoreboard, then pop it
  task automatic consume(input string name);
    bit seen = 0;
    logic [2:0] e;
    for (int k = 0; k < 64; k++) begin
      if (evt_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!seen || expq.size() == 0) begin
      bad++;
      $display("FAIL %s: evt_valid=%0b queued_expected=%0d", name, evt_valid, expq.size());
    end else begin
      e = expq.pop_front();
      if ({evt_ch, evt_rise} !== e) begin
        bad++;
        $display("FAIL %s: got ch=%0d rise=%0b, required ch=%0d rise=%0b", name, evt_ch, evt_rise, e[2:1], e[0]);
      end
      evt_ready = 1'b1;
      step(1);
      evt_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    int first = 0;
    sw = 4'b0001;
    wait_scans(3);
    step(2);
    total++;
    if ({db, evt_valid} !== 5'b00011) begin
      bad++;
      $display("FAIL pre_reset: got db=%b valid=%b, required db=0001 valid=1", db, evt_valid);
    end
    rst_n = 1'b0;
    sw = '0;
    step(3);
    total++;
    if ({db, tick, evt_valid, overflow, evt_ch, evt_rise} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs: got db=%b tick=%b valid=%b ovf=%b ch=%0d rise=%b, required all 0",
               db, tick, evt_valid, overflow, evt_ch, evt_rise);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (tick) begin
        first = k;
        break;
      end
    end
    total++;
    if (first != 15) begin
      bad++;
      $display("FAIL first_tick: got tick after %0d edges, required 15 (16th cycle)", first);
    end
    step(1);
    total++;
    if (tick !== 1'b0) begin
      bad++;
      $display("FAIL tick_width: got tick=%b in following cycle, required 0", tick);
    end
  endtask

  task automatic test_single_press();
    wait_tick();
    step(6);
    sw[2] = 1'b1;
    expq.push_back({2'd2, 1'b1});
    wait_scans(2);
    step(5);
    total++;
    if ({db, evt_valid} !== 5'b00000) begin
      bad++;
      $display("FAIL single_early: got db=%b valid=%b, required db=0000 valid=0", db, evt_valid);
    end
    wait_tick();
    step(3);
    total++;
    if (db[2] !== 1'b0) begin
      bad++;
      $display("FAIL single_slot: got db[2]=%b during slot, required 0", db[2]);
    end
    step(1);
    total++;
    if ({db, evt_valid} !== 5'b01001) begin
      bad++;
      $display("FAIL single_flip: got db=%b valid=%b, required db=0100 valid=1", db, evt_valid);
    end
    step(5);
    total++;
    if ({evt_valid, evt_ch, evt_rise} !== 4'b1101) begin
      bad++;
      $display("FAIL single_hold: got valid=%b ch=%0d rise=%b, required valid=1 ch=2 rise=1", evt_valid, evt_ch, evt_rise);
    end
    consume("single_evt");
    total++;
    if (evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_popped: got evt_valid=%b, required 0", evt_valid);
    end
  endtask

  task automatic test_glitch();
    wait_tick();
    step(6);
    sw[1] = 1'b1;
    wait_scans(2);
    sw[1] = 1'b0;
    wait_tick();
    step(6);
    sw[1] = 1'b1;
    expq.push_back({2'd1, 1'b1});
    wait_scans(2);
    step(6);
    total++;
    if ({db[1], evt_valid} !== 2'b00) begin
      bad++;
      $display("FAIL glitch_early: got db[1]=%b valid=%b, required 0 0", db[1], evt_valid);
    end
    wait_tick();
    step(2);
    evt_ready = 1'b1;
    step(1);
    total++;
    if ({db[1], evt_valid, evt_ch, evt_rise} !== 5'b11011) begin
      bad++;
      $display("FAIL glitch_flip: got db[1]=%b valid=%b ch=%0d rise=%b, required db[1]=1 valid=1 ch=1 rise=1",
               db[1], evt_valid, evt_ch, evt_rise);
    end
    evt_ready = 1'b0;
    consume("glitch_evt");
    wait_tick();
    step(6);
    total++;
    if (evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL glitch_single: got evt_valid=%b, required 0", evt_valid);
    end
  endtask

  task automatic test_fill_overflow();
    wait_tick();
    step(6);
    sw = ~sw;
    for (int i = 0; i < 4; i++) expq.push_back({2'(i), sw[i]});
    wait_scans(3);
    step(5);
    total++;
    if ({db, evt_valid, overflow} !== {sw, 2'b10}) begin
      bad++;
      $display("FAIL fill: got db=%b valid=%b ovf=%b, required db=%b valid=1 ovf=0", db, evt_valid, overflow, sw);
    end
    sw[0] = ~sw[0];
    wait_scans(3);
    step(1);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_before_drop: got overflow=%b, required 0", overflow);
    end
    step(1);
    total++;
    if ({overflow, db[0]} !== {1'b1, sw[0]}) begin
      bad++;
      $display("FAIL drop: got ovf=%b db[0]=%b, required ovf=1 db[0]=%b", overflow, db[0], sw[0]);
    end
    step(4);
    sw[1] = ~sw[1];
    wait_scans(3);
    step(2);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    total++;
    if ({overflow, db[1]} !== {1'b1, sw[1]}) begin
      bad++;
      $display("FAIL clr_vs_drop: got ovf=%b db[1]=%b, required ovf=1 db[1]=%b", overflow, db[1], sw[1]);
    end
    for (int i = 0; i < 4; i++) consume("fill_drain");
    total++;
    if (evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL fill_empty: got evt_valid=%b, required 0", evt_valid);
    end
  endtask

  task automatic test_clr_ovf();
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL clr_ovf: got overflow=%b, required 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    wait_tick();
    step(6);
    sw = ~sw;
    for (int i = 0; i < 4; i++) expq.push_back({2'(i), sw[i]});
    wait_scans(3);
    step(5);
    sw[0] = ~sw[0];
    wait_scans(3);
    step(1);
    e = expq.pop_front();
    total++;
    if ({evt_valid, evt_ch, evt_rise} !== {1'b1, e}) begin
      bad++;
      $display("FAIL b2b_head: got valid=%b ch=%0d rise=%b, required valid=1 ch=%0d rise=%b",
               evt_valid, evt_ch, evt_rise, e[2:1], e[0]);
    end
    evt_ready = 1'b1;
    expq.push_back({2'd0, sw[0]});
    step(1);
    evt_ready = 1'b0;
    total++;
    if ({overflow, evt_valid, db[0]} !== {2'b01, sw[0]}) begin
      bad++;
      $display("FAIL b2b_accept: got ovf=%b valid=%b db[0]=%b, required ovf=0 valid=1 db[0]=%b",
               overflow, evt_valid, db[0], sw[0]);
    end
    for (int i = 0; i < 4; i++) consume("b2b_drain");
    total++;
    if ({evt_valid, overflow} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_empty: got valid=%b ovf=%b, required 0 0", evt_valid, overflow);
    end
  endtask

  initial begin
    step(2);
    rst_n = 1'b1;
    test_reset();
    test_single_press();
    test_glitch();
    test_fill_overflow();
    test_clr_ovf();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
